// File: rtl/i8080_host_tx_if.sv
// i8080 host transmitter bundle: command port, pixel stream,
// frame control, slave line window and the registered 8080 bus.
interface i8080_host_tx_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       frame_start;
    logic       abort;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_last;
    logic       pix_ready;
    logic       J80_Re;
    logic       J80_RS;
    logic       J80_We;
    logic [7:0] J80_Data;
    logic       busy;
    logic       frame_done;
    logic       err;

    modport master (
        input  cmd_valid, cmd_data, frame_start, abort,
        input  pix_valid, pix_data, pix_last, J80_Re,
        output cmd_ready, pix_ready, J80_RS, J80_We, J80_Data,
        output busy, frame_done, err
    );

    modport slave (
        output cmd_valid, cmd_data, frame_start, abort,
        output pix_valid, pix_data, pix_last, J80_Re,
        input  cmd_ready, pix_ready, J80_RS, J80_We, J80_Data,
        input  busy, frame_done, err
    );
endinterface

// File: rtl/i8080_host_tx.sv
// Host-side i8080 transmitter: register writes, framed pixel lines
// paced by the slave J80_Re window, automatic Frame Start/End writes.
module i8080_host_tx #(
    parameter int         BYTES_PER_LINE = 1600,
    parameter int         LINES          = 480,
    parameter logic [7:0] FSTART_CODE    = 8'h41,
    parameter logic [7:0] FEND_CODE      = 8'h40
) (
    input  logic           J80_CLK,
    input  logic           nRST,
    i8080_host_tx_if.master bus
);
    localparam int BW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [BW-1:0] BYTE_MAX = BW'(BYTES_PER_LINE - 1);
    localparam logic [LW-1:0] LINE_MAX = LW'(LINES - 1);

    typedef enum logic [2:0] {
        IDLE, FSTART, WAIT_HI, LINE, WAIT_LO, FEND
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] byte_cnt, byte_cnt_n;
    logic [LW-1:0] line_cnt, line_cnt_n;
    logic          rdy_en;
    logic          fend_q;
    logic          wr_en;
    logic          wr_rs;
    logic [7:0]    wr_data;
    logic          pix_hs;
    logic          final_byte;

    assign final_byte = (byte_cnt == BYTE_MAX) && (line_cnt == LINE_MAX);
    assign pix_hs     = bus.pix_valid & bus.pix_ready;
    assign bus.busy   = (state != IDLE);

    always_comb begin
        state_n       = state;
        byte_cnt_n    = byte_cnt;
        line_cnt_n    = line_cnt;
        bus.cmd_ready = 1'b0;
        bus.pix_ready = 1'b0;
        wr_en         = 1'b0;
        wr_rs         = 1'b1;
        wr_data       = 8'h00;
        unique case (state)
            IDLE: begin
                if (bus.frame_start) state_n = FSTART;
                else bus.cmd_ready = rdy_en;
            end
            FSTART: begin
                wr_en      = 1'b1;
                wr_data    = FSTART_CODE;
                byte_cnt_n = '0;
                line_cnt_n = '0;
                state_n    = bus.abort ? FEND : WAIT_HI;
            end
            WAIT_HI: begin
                bus.cmd_ready = ~bus.J80_Re;
                if (bus.abort) state_n = FEND;
                else if (bus.J80_Re) state_n = LINE;
            end
            LINE: begin
                bus.pix_ready = bus.J80_Re & ~bus.abort;
                if (bus.abort) begin
                    state_n = FEND;
                end else if (pix_hs) begin
                    wr_en   = 1'b1;
                    wr_rs   = 1'b0;
                    wr_data = bus.pix_data;
                    if (byte_cnt == BYTE_MAX) begin
                        byte_cnt_n = '0;
                        if (line_cnt == LINE_MAX) begin
                            line_cnt_n = '0;
                            state_n    = FEND;
                        end else begin
                            line_cnt_n = line_cnt + LW'(1);
                            state_n    = WAIT_LO;
                        end
                    end else begin
                        byte_cnt_n = byte_cnt + BW'(1);
                    end
                end
            end
            // a window that just carried a line must close before the next
            WAIT_LO: begin
                bus.cmd_ready = 1'b1;
                if (bus.abort) state_n = FEND;
                else if (!bus.J80_Re) state_n = WAIT_HI;
            end
            FEND: begin
                wr_en   = 1'b1;
                wr_data = FEND_CODE;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (bus.cmd_valid & bus.cmd_ready) begin
            wr_en   = 1'b1;
            wr_rs   = 1'b1;
            wr_data = bus.cmd_data;
        end
    end

    always_ff @(posedge J80_CLK or negedge nRST) begin
        if (!nRST) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            line_cnt       <= '0;
            rdy_en         <= 1'b0;
            fend_q         <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.err        <= 1'b0;
            bus.J80_RS     <= 1'b0;
            bus.J80_We     <= 1'b0;
            bus.J80_Data   <= 8'h00;
        end else begin
            state          <= state_n;
            byte_cnt       <= byte_cnt_n;
            line_cnt       <= line_cnt_n;
            rdy_en         <= 1'b1;
            fend_q         <= (state == FEND);
            bus.frame_done <= fend_q;
            bus.J80_We     <= wr_en;
            bus.J80_Data   <= wr_en ? wr_data : 8'h00;
            if (wr_en) bus.J80_RS <= wr_rs;
            if ((state == IDLE) && bus.frame_start) bus.err <= 1'b0;
            else if (pix_hs && (bus.pix_last != final_byte)) bus.err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_i8080_host_tx.sv
// Bench for i8080_host_tx: cycle-indexed write schedule model plus
// directed frames (normal, line gap, window hold, err, abort, reset).
module tb_i8080_host_tx;
    localparam int         B  = 4;
    localparam int         L  = 2;
    localparam logic [7:0] FS = 8'h41;
    localparam logic [7:0] FE = 8'h40;

    logic clk  = 1'b0;
    logic nRST = 1'b0;
    always #5 clk = ~clk;

    i8080_host_tx_if bus ();

    i8080_host_tx #(
        .BYTES_PER_LINE(B), .LINES(L),
        .FSTART_CODE(FS), .FEND_CODE(FE)
    ) dut (
        .J80_CLK(clk),
        .nRST(nRST),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    // model: expected bus words and pulses keyed by cycle number
    int         cyc;
    logic [8:0] due[int];
    bit         dn_due[int];
    bit         busy_sch[int];
    bit         err_sch[int];
    bit         m_busy, m_err, m_act, line_open, need_low, legal;
    int         m_from, m_cnt;
    int         n_acc, n_done;
    logic [8:0] wr_log[$];
    int         wr_cyc[$];
    bit         stop_feed;
    bit         feed_done = 1'b1;

    function void sched_fend(input int t);
        due[t+2]      = {1'b1, FE};
        dn_due[t+3]   = 1'b1;
        busy_sch[t+2] = 1'b0;
        m_act         = 1'b0;
        line_open     = 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!nRST) begin
            cyc = 0;
            due.delete();
            dn_due.delete();
            busy_sch.delete();
            err_sch.delete();
            m_busy = 0; m_err = 0; m_act = 0;
            line_open = 0; need_low = 0;
        end else begin
            cyc++;
            if (busy_sch.exists(cyc)) m_busy = busy_sch[cyc];
            if (err_sch.exists(cyc)) m_err = err_sch[cyc];
            chk("bus_we", bus.J80_We, due.exists(cyc));
            if (due.exists(cyc)) begin
                chk("bus_word", {bus.J80_RS, bus.J80_Data}, due[cyc]);
                due.delete(cyc);
            end else begin
                chk("bus_idle_data", bus.J80_Data, 0);
            end
            if (bus.J80_We) begin
                wr_log.push_back({bus.J80_RS, bus.J80_Data});
                wr_cyc.push_back(cyc);
            end
            chk("frame_done", bus.frame_done, dn_due.exists(cyc));
            if (bus.frame_done) n_done++;
            chk("busy", bus.busy, m_busy);
            chk("err", bus.err, m_err);
            chk("ready_excl", bus.cmd_ready & bus.pix_ready, 0);
            legal = m_act && line_open && bus.J80_Re && !bus.abort;
            chk("pix_ready_window", bus.pix_ready & ~legal, 0);
            if (!m_busy && cyc >= 2)
                chk("cmd_ready_idle", bus.cmd_ready, !bus.frame_start);
            if (bus.cmd_valid && bus.cmd_ready)
                due[cyc+1] = {1'b1, bus.cmd_data};
            if (bus.pix_valid && bus.pix_ready) begin
                due[cyc+1] = {1'b0, bus.pix_data};
                n_acc++;
                if (bus.pix_last != (m_cnt == B*L-1)) err_sch[cyc+1] = 1'b1;
                m_cnt++;
                if (m_cnt == B*L) sched_fend(cyc);
                else if (m_cnt % B == 0) begin
                    line_open = 0;
                    need_low  = 1;
                end
            end else if (bus.abort && m_act && cyc >= m_from) begin
                sched_fend(cyc);
            end
            if (!m_busy && bus.frame_start) begin
                due[cyc+2]      = {1'b1, FS};
                busy_sch[cyc+1] = 1'b1;
                err_sch[cyc+1]  = 1'b0;
                m_act = 1; m_from = cyc + 1; m_cnt = 0;
                need_low = 0; line_open = 0;
            end
            if (need_low && !bus.J80_Re) need_low = 0;
            else if (m_act && cyc >= m_from + 1 && !need_low && bus.J80_Re)
                line_open = 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_cmd(input logic [7:0] d);
        bit ok;
        ok = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bus.cmd_ready;
            @(posedge clk);
            #2;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) timeout("cmd_accept");
    endtask

    task automatic feed(input int n, input int last_idx);
        bit ok;
        feed_done = 0;
        for (int i = 0; i < n && !stop_feed; i++) begin
            ok = 0;
            bus.pix_valid = 1'b1;
            bus.pix_data  = 8'(i + 1);
            bus.pix_last  = (i == last_idx);
            for (int k = 0; k < 300 && !ok && !stop_feed; k++) begin
                @(negedge clk);
                ok = bus.pix_ready;
                @(posedge clk);
                #2;
            end
            if (!ok && !stop_feed) begin
                timeout("pix_accept");
                break;
            end
        end
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        feed_done = 1;
    endtask

    task automatic wait_acc(input int n);
        for (int k = 0; k < 200 && n_acc < n; k++) tick(1);
        if (n_acc < n) timeout("wait_acc");
    endtask

    task automatic fs();
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
    endtask

    task automatic run_frame(input int last_idx, input int abort_after,
                             input bit gap, input bit hold,
                             output int base);
        int d0;
        base  = wr_log.size();
        d0    = n_done;
        n_acc = 0;
        stop_feed = 0;
        fs();
        chk("err_clear_on_start", bus.err, 0);
        tick(1);
        send_cmd(8'h2A);
        bus.J80_Re = 1'b1;
        fork
            feed(B*L, last_idx);
        join_none
        if (abort_after >= 0) begin
            wait_acc(abort_after);
            bus.abort = 1'b1;
            tick(1);
            bus.abort = 1'b0;
            stop_feed = 1;
        end else begin
            if (gap) begin
                wait_acc(2);
                bus.J80_Re = 1'b0;
                tick(5);
                bus.J80_Re = 1'b1;
            end
            wait_acc(B);
            if (hold) begin
                tick(4);
                chk("hold_no_accept", n_acc, B);
            end
            bus.J80_Re = 1'b0;
            tick(2);
            bus.J80_Re = 1'b1;
            wait_acc(B*L);
        end
        for (int k = 0; k < 30 && n_done == d0; k++) tick(1);
        if (n_done == d0) timeout("frame_done_wait");
        chk("frame_done_count", n_done - d0, 1);
        for (int k = 0; k < 50 && !feed_done; k++) tick(1);
        if (!feed_done) timeout("feeder_end");
        bus.J80_Re = 1'b0;
    endtask

    logic [8:0] exp_full[11] = '{9'h141, 9'h12A, 9'h001, 9'h002,
        9'h003, 9'h004, 9'h005, 9'h006, 9'h007, 9'h008, 9'h140};
    logic [8:0] exp_abrt[5] = '{9'h141, 9'h12A, 9'h001, 9'h002, 9'h140};

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        bus.cmd_valid = 0; bus.cmd_data = 0; bus.frame_start = 0;
        bus.abort = 0; bus.pix_valid = 0; bus.pix_data = 0;
        bus.pix_last = 0; bus.J80_Re = 0;
        stop_feed = 0;
        repeat (3) @(negedge clk);
        chk("rst_rs", bus.J80_RS, 0);
        chk("rst_we", bus.J80_We, 0);
        chk("rst_data", bus.J80_Data, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_pix_ready", bus.pix_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_err", bus.err, 0);
        @(posedge clk);
        #2 nRST = 1'b1;
        @(negedge clk);
        chk("cmd_ready_before_edge", bus.cmd_ready, 0);
        @(negedge clk);
        chk("cmd_ready_after_edge", bus.cmd_ready, 1);
        tick(1);

        send_cmd(8'h3F);
        @(negedge clk);
        chk("cmd_bus", {bus.J80_RS, bus.J80_We, bus.J80_Data}, 10'h33F);
        chk("cmd_busy", bus.busy, 0);
        tick(2);

        // normal frame, window held high across the line end
        run_frame(7, -1, 0, 1, base);
        chk("full_len", wr_log.size() - base, 11);
        for (int i = 0; i < 11; i++)
            if (base + i < wr_log.size())
                chk("full_seq", wr_log[base+i], exp_full[i]);
        chk("full_err", bus.err, 0);
        tick(3);

        // window gap after byte 2, pix_last wrongly on byte 3
        run_frame(2, -1, 1, 0, base);
        chk("gap_len", wr_log.size() - base, 11);
        for (int i = 0; i < 11; i++)
            if (base + i < wr_log.size())
                chk("gap_seq", wr_log[base+i], exp_full[i]);
        if (base + 4 < wr_cyc.size())
            chk("gap_cycles", wr_cyc[base+4] - wr_cyc[base+3], 6);
        chk("err_sticky", bus.err, 1);
        tick(3);
        chk("err_held_idle", bus.err, 1);

        // abort after two bytes of the first line
        run_frame(7, 2, 0, 0, base);
        chk("abort_len", wr_log.size() - base, 5);
        for (int i = 0; i < 5; i++)
            if (base + i < wr_log.size())
                chk("abort_seq", wr_log[base+i], exp_abrt[i]);
        tick(3);

        // reset in the middle of a frame
        n_acc = 0;
        stop_feed = 0;
        fs();
        tick(1);
        bus.J80_Re = 1'b1;
        fork
            feed(B*L, B*L-1);
        join_none
        wait_acc(1);
        base = wr_log.size();
        nRST = 1'b0;
        stop_feed = 1;
        #1;
        chk("mid_rst_we", bus.J80_We, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_pix_ready", bus.pix_ready, 0);
        chk("mid_rst_data", bus.J80_Data, 0);
        bus.J80_Re = 1'b0;
        tick(3);
        nRST = 1'b1;
        tick(4);
        chk("mid_rst_no_fend", wr_log.size() - base, 0);
        send_cmd(8'h5A);
        @(negedge clk);
        chk("post_rst_cmd", {bus.J80_RS, bus.J80_We, bus.J80_Data}, 10'h35A);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
